impulse_scheduler: RTL and testbench

//  Arbitrates excitation requests from N_REQ sources (HPS registers, MIDI decoder) onto one

---
 rtl/impulse_scheduler.sv | 153 +++++++++++++++
 tb/tb_impulse_scheduler.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/impulse_scheduler.sv
// impulse_scheduler: round-robin arbiter feeding one shared triangle-impulse force generator
// Optional IMPULSE_SCHED_GAIN_EN adds a per-requester 8-bit gain and one extra output stage.
module impulse_scheduler #(
  parameter int N_REQ      = 4,
  parameter int SIZE_PWR   = 8,
  parameter int MASS_IDX_W = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sample_tick,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*MASS_IDX_W-1:0]   req_mass,
  input  logic [N_REQ-1:0]              req_neg,
`ifdef IMPULSE_SCHED_GAIN_EN
  input  logic [N_REQ*8-1:0]            req_gain,
`endif
  input  logic                          abort,
  output logic                          force_valid,
  output logic signed [26:0]            force_out,
  output logic [MASS_IDX_W-1:0]         force_mass,
  output logic                          busy,
  output logic [$clog2(N_REQ)-1:0]      grant_id
);
  localparam int GW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, ARM, PLAY} state_t;
  state_t                  state_q, state_d;
  logic [N_REQ-1:0]        pending_q, pending_d, clr;
  logic [GW-1:0]           last_grant_q, last_grant_d, grant_id_q, grant_id_d, gnt;
  logic [SIZE_PWR-1:0]     count_q, count_d;
  logic [MASS_IDX_W-1:0]   mass_q, mass_d, force_mass_q, force_mass_d, msel;
  logic                    neg_q, neg_d, force_valid_q, force_valid_d, fire, vld, sgn;
  logic signed [26:0]      force_out_q, force_out_d, sm;
  logic [SIZE_PWR-2:0]     tri_v;
  logic [24:0]             mag;
`ifdef IMPULSE_SCHED_GAIN_EN
  logic [7:0]              gain_q, gain_d, pgain_q, pgain_d;
  logic [24:0]             pmag_q, pmag_d;
  logic                    pv_q, pv_d, pneg_q, pneg_d;
  logic [MASS_IDX_W-1:0]   pmass_q, pmass_d;
`endif
  // Rotating priority: the lowest offset after last_grant wins.
  always_comb begin
    gnt = last_grant_q;
    for (int k = N_REQ; k >= 1; k--)
      if (pending_q[(int'(last_grant_q) + k) % N_REQ]) gnt = GW'((int'(last_grant_q) + k) % N_REQ);
  end
  // Falling half of the triangle is the bitwise complement of the count.
  assign tri_v = count_q[SIZE_PWR-1] ? ~count_q[SIZE_PWR-2:0] : count_q[SIZE_PWR-2:0];
  assign mag   = 25'(tri_v) << (26 - SIZE_PWR);
  assign fire  = state_q == PLAY && sample_tick && !abort;
  assign clr   = state_q == ARM ? N_REQ'(1) << gnt : '0;
  always_comb begin
    state_d      = state_q;
    pending_d    = (pending_q & ~clr) | req;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    count_d      = count_q;
    mass_d       = mass_q;
    neg_d        = neg_q;
`ifdef IMPULSE_SCHED_GAIN_EN
    gain_d       = gain_q;
`endif
    case (state_q)
      IDLE: state_d = |pending_q ? ARM : IDLE;
      ARM: begin
        mass_d       = req_mass[int'(gnt)*MASS_IDX_W +: MASS_IDX_W];
        neg_d        = req_neg[gnt];
`ifdef IMPULSE_SCHED_GAIN_EN
        gain_d       = req_gain[int'(gnt)*8 +: 8];
`endif
        grant_id_d   = gnt;
        last_grant_d = gnt;
        count_d      = '0;
        state_d      = PLAY;
      end
      PLAY: begin
        count_d = fire ? count_q + 1'b1 : count_q;
        state_d = abort || (fire && &count_q) ? IDLE : PLAY;
      end
      default: state_d = IDLE;
    endcase
  end
`ifdef IMPULSE_SCHED_GAIN_EN
  // Stage one captures the raw sample; stage two scales it unsigned, then applies the sign.
  always_comb begin
    pv_d    = fire;
    pmag_d  = fire ? mag : '0;
    pneg_d  = fire && neg_q;
    pmass_d = fire ? mass_q : '0;
    pgain_d = fire ? gain_q : '0;
    vld     = pv_q;
    sgn     = pneg_q;
    msel    = pmass_q;
    sm      = 27'(25'((33'(pmag_q) * 33'(pgain_q)) >> 8));
  end
`else
  always_comb begin
    vld  = fire;
    sgn  = neg_q;
    msel = mass_q;
    sm   = 27'(mag);
  end
`endif
  assign force_valid_d = vld;
  assign force_out_d   = vld ? (sgn ? -sm : sm) : '0;
  assign force_mass_d  = vld ? msel : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      last_grant_q  <= GW'(N_REQ - 1);
      grant_id_q    <= '0;
      count_q       <= '0;
      mass_q        <= '0;
      neg_q         <= 1'b0;
      force_valid_q <= 1'b0;
      force_out_q   <= '0;
      force_mass_q  <= '0;
`ifdef IMPULSE_SCHED_GAIN_EN
      gain_q        <= '0;
      pv_q          <= 1'b0;
      pmag_q        <= '0;
      pneg_q        <= 1'b0;
      pmass_q       <= '0;
      pgain_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      count_q       <= count_d;
      mass_q        <= mass_d;
      neg_q         <= neg_d;
      force_valid_q <= force_valid_d;
      force_out_q   <= force_out_d;
      force_mass_q  <= force_mass_d;
`ifdef IMPULSE_SCHED_GAIN_EN
      gain_q        <= gain_d;
      pv_q          <= pv_d;
      pmag_q        <= pmag_d;
      pneg_q        <= pneg_d;
      pmass_q       <= pmass_d;
      pgain_q       <= pgain_d;
`endif
    end
  end
  assign force_valid = force_valid_q;
  assign force_out   = force_out_q;
  assign force_mass  = force_mass_q;
  assign busy        = state_q != IDLE;
  assign grant_id    = grant_id_q;
endmodule

// File: tb/tb_impulse_scheduler.sv
// tb_impulse_scheduler: directed + randomized checks of impulse_scheduler against an arithmetic model
module tb_impulse_scheduler;
  localparam int N = 4, SP = 8, MW = 10, L = 2**SP;
`ifdef IMPULSE_SCHED_GAIN_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0, reset = 1'b1, sample_tick = 1'b0, abort = 1'b0;
  logic [N-1:0] req = '0, req_neg = '0;
  logic [N*MW-1:0] req_mass = '0;
`ifdef IMPULSE_SCHED_GAIN_EN
  logic [N*8-1:0] req_gain = '0;
`endif
  logic force_valid, busy;
  logic signed [26:0] force_out;
  logic [MW-1:0] force_mass;
  logic [1:0] grant_id;
  int checks = 0, errors = 0;
  logic [N-1:0] pend_m;
  int lg_m;
  impulse_scheduler #(.N_REQ(N), .SIZE_PWR(SP), .MASS_IDX_W(MW)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .req(req), .req_mass(req_mass),
    .req_neg(req_neg),
`ifdef IMPULSE_SCHED_GAIN_EN
    .req_gain(req_gain),
`endif
    .abort(abort), .force_valid(force_valid), .force_out(force_out),
    .force_mass(force_mass), .busy(busy), .grant_id(grant_id));
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    req = '0;
    sample_tick = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
  endtask
  function automatic int next_grant();
    for (int k = 1; k <= N; k++)
      if (pend_m[(lg_m + k) % N]) return (lg_m + k) % N;
    return 0;
  endfunction
  function automatic longint exp_force(int k, bit n, int g);
    longint t = (k < L/2) ? k : L - 1 - k;
    longint m = (t * (2**(26-SP)) * g) / 256;
    return n ? -m : m;
  endfunction
  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, force_valid, 0);
    chk({tag, "_out"}, force_out, 0);
    chk({tag, "_mass"}, force_mass, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_gid"}, grant_id, 0);
  endtask
  task automatic do_reset();
    step();
    reset = 1'b1;
    step();
    pend_m = '0;
    lg_m = N - 1;
  endtask
  task automatic pulse(input logic [N-1:0] b);
    step();
    req = b;
    pend_m |= b;
    repeat (3) step();
    chk("busy_after_req", busy, 1);
  endtask
  // Plays one impulse; cut >= 0 stops it at that sample by abort (cut_rst=0) or reset (cut_rst=1).
  task automatic run(input int period, input logic [N-1:0] inj, input int inj_at, input int cut, input bit cut_rst);
    int id, m, g;
    bit n;
    id = next_grant();
    pend_m[id] = 1'b0;
    lg_m = id;
    m = int'(req_mass[id*MW +: MW]);
    n = req_neg[id];
`ifdef IMPULSE_SCHED_GAIN_EN
    g = int'(req_gain[id*8 +: 8]);
`else
    g = 256;
`endif
    for (int k = 0; k < L; k++) begin
      if (k == cut) begin
        if (cut_rst) begin
          step();
          reset = 1'b1;
          step();
          chk_zero("reset_mid");
          repeat (3) step();
          chk("reset_pending_lost", busy, 0);
          pend_m = '0;
          lg_m = N - 1;
        end else begin
          step();
          sample_tick = 1'b1;
          abort = 1'b1;
          step();
          chk("abort_valid", force_valid, 0);
          chk("abort_busy", busy, 0);
          repeat (period - 2) step();
        end
        return;
      end
      step();
      sample_tick = 1'b1;
      step();
      if (k == inj_at) begin
        req = inj;
        pend_m |= inj;
      end
      repeat (LAT - 1) step();
      chk("valid", force_valid, 1);
      chk($sformatf("force_k%0d", k), force_out, exp_force(k, n, g));
      chk("mass", force_mass, m);
      chk("grant_id", grant_id, id);
      if (k == L - 1 && (LAT == 1 || pend_m == 0)) chk("busy_end", busy, 0);
      step();
      chk("valid_gap", force_valid, 0);
      repeat (period - 2 - LAT) step();
    end
  endtask
  initial begin
    for (int i = 0; i < N; i++) req_mass[i*MW +: MW] = MW'($urandom);
`ifdef IMPULSE_SCHED_GAIN_EN
    for (int i = 0; i < N; i++) req_gain[i*8 +: 8] = 8'($urandom);
    req_gain[7:0] = 8'd128;
`endif
    pend_m = '0;
    lg_m = N - 1;
    repeat (2) @(negedge clk);
    chk_zero("in_reset");
    step();
    chk_zero("after_reset");
    req_mass[MW-1:0] = 10'd5;
    pulse(4'b0001);
    run(16, '0, -1, -1, 1'b0);
    do_reset();
    pulse(4'b1111);
    repeat (4) run(4, '0, -1, -1, 1'b0);
    pulse(4'b0010);
    run(4, 4'b1001, 20, -1, 1'b0);
    run(4, '0, -1, -1, 1'b0);
    run(4, '0, -1, -1, 1'b0);
    pulse(4'b0001);
    run(4, 4'b0100, 3, 10, 1'b0);
    run(4, '0, -1, -1, 1'b0);
    req_neg[1] = 1'b1;
`ifdef IMPULSE_SCHED_GAIN_EN
    req_gain[15:8] = 8'd0;
`endif
    pulse(4'b0010);
    run(4, '0, -1, -1, 1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) req_mass[i*MW +: MW] = MW'($urandom);
      req_neg = N'($urandom);
`ifdef IMPULSE_SCHED_GAIN_EN
      for (int i = 0; i < N; i++) req_gain[i*8 +: 8] = 8'($urandom);
`endif
      pulse(N'($urandom_range(1, 15)));
      for (int n = 0; n < 8 && pend_m != 0; n++)
        run(4, n < 2 ? N'($urandom) : '0, $urandom_range(1, 200), -1, 1'b0);
    end
    pulse(4'b0011);
    run(4, 4'b0100, 2, 5, 1'b1);
    pulse(4'b1000);
    run(4, '0, -1, -1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
